// File: rtl/bcd_counter_scan_pkg.sv
// Shared constants and single-digit BCD arithmetic for the scanned BCD counter.
package bcd_counter_scan_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef struct packed {
    logic [BCD_W-1:0] value;
    logic             carry;
  } bcd_step_t;

  function automatic logic is_bcd(input logic [BCD_W-1:0] nib);
    return (nib <= BCD_MAX);
  endfunction

  // carry doubles as borrow when counting down
  function automatic bcd_step_t bcd_step(input logic [BCD_W-1:0] val,
                                         input logic step,
                                         input logic up);
    bcd_step_t r;
    r.value = val;
    r.carry = 1'b0;
    if (step) begin
      if (up) begin
        if (val >= BCD_MAX) begin
          r.value = '0;
          r.carry = 1'b1;
        end else begin
          r.value = val + BCD_W'(1);
        end
      end else begin
        if (val == '0) begin
          r.value = BCD_MAX;
          r.carry = 1'b1;
        end else begin
          r.value = val - BCD_W'(1);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_counter_scan_digit.sv
// One BCD digit step cell: next value plus carry/borrow out for the ripple chain.
module bcd_digit
  import bcd_counter_scan_pkg::*;
(
  input  logic [BCD_W-1:0] val_i,
  input  logic             step_i,
  input  logic             up_i,
  output logic [BCD_W-1:0] next_o,
  output logic             carry_o
);

  bcd_step_t res;

  assign res     = bcd_step(val_i, step_i, up_i);
  assign next_o  = res.value;
  assign carry_o = res.carry;

endmodule

// File: rtl/bcd_counter_scan.sv
// Multi-digit BCD up/down counter with a time-multiplexed digit scanner
// feeding a single BCD-to-7-segment decoder.
module bcd_counter_scan
  import bcd_counter_scan_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_val,
  input  logic                    en,
  input  logic                    up,
  input  logic                    lzb,
  output logic [BCD_W*DIGITS-1:0] count,
  output logic                    wrap,
  output logic                    load_err,
  output logic [BCD_W-1:0]        bcd_out,
  output logic [DIGITS-1:0]       digit_sel,
  output logic                    blank
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIV_W = $clog2(SCAN_DIV);

  logic [BCD_W*DIGITS-1:0] count_q, count_d;
  logic [BCD_W*DIGITS-1:0] step_val, load_clean;
  logic [DIGITS:0]         carry;
  logic [DIGITS-1:0]       nib_bad;
  logic                    wrap_q, wrap_d;
  logic                    load_err_q, load_err_d;

  logic [DIV_W-1:0]        div_q, div_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [BCD_W-1:0]        bcd_q, bcd_d;
  logic [DIGITS-1:0]       sel_q, sel_d;
  logic                    blank_q, blank_d;
  logic [DIGITS-1:0]       upper_zero;

  // digit 0 always steps; the chain result is only used when en is high
  assign carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_digit u_digit (
        .val_i   (count_q[gi*BCD_W +: BCD_W]),
        .step_i  (carry[gi]),
        .up_i    (up),
        .next_o  (step_val[gi*BCD_W +: BCD_W]),
        .carry_o (carry[gi+1])
      );

      assign nib_bad[gi] = !is_bcd(load_val[gi*BCD_W +: BCD_W]);
      assign load_clean[gi*BCD_W +: BCD_W] =
        nib_bad[gi] ? '0 : load_val[gi*BCD_W +: BCD_W];

      if (gi == DIGITS - 1) begin : g_top
        assign upper_zero[gi] = (count_q[gi*BCD_W +: BCD_W] == '0);
      end else begin : g_mid
        assign upper_zero[gi] = (count_q[gi*BCD_W +: BCD_W] == '0) && upper_zero[gi+1];
      end
    end
  endgenerate

  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d    = load_clean;
      load_err_d = |nib_bad;
    end else if (en) begin
      count_d = step_val;
      wrap_d  = carry[DIGITS];
    end
  end

  always_comb begin
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end else begin
      div_d = div_q + DIV_W'(1);
      idx_d = idx_q;
    end
  end

  // display outputs are built from the previous cycle's index and count
  always_comb begin
    bcd_d   = '0;
    sel_d   = '0;
    blank_d = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        bcd_d    = count_q[i*BCD_W +: BCD_W];
        sel_d[i] = 1'b1;
        blank_d  = lzb && (i != 0) && upper_zero[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
      div_q      <= '0;
      idx_q      <= '0;
      bcd_q      <= '0;
      sel_q      <= DIGITS'(1);
      blank_q    <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
      div_q      <= div_d;
      idx_q      <= idx_d;
      bcd_q      <= bcd_d;
      sel_q      <= sel_d;
      blank_q    <= blank_d;
    end
  end

  assign count     = count_q;
  assign wrap      = wrap_q;
  assign load_err  = load_err_q;
  assign bcd_out   = bcd_q;
  assign digit_sel = sel_q;
  assign blank     = blank_q;

endmodule
